// File: rtl/smc_sccb_slave.sv
// SCCB responder with an internal 8-bit register file and write/read event ports.
// Define SMC_SLV_AUTO_INC_EN to auto-increment the sub-address pointer after every data byte.
module smc_sccb_slave #(
    parameter logic [6:0]  SLV_ID      = 7'h21,
    parameter int unsigned REG_NUM     = 256,
    parameter logic [7:0]  REG_RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sio_c_i,
    input  logic       sio_d_i,
    output logic       sio_d_oe_o,
    output logic       wr_evt_vld_o,
    output logic [7:0] wr_evt_addr_o,
    output logic [7:0] wr_evt_data_o,
    output logic       rd_evt_vld_o,
    output logic       busy_o,
    input  logic [7:0] dbg_addr_i,
    output logic [7:0] dbg_data_o
);

    localparam logic [8:0] LP_REG_NUM = 9'(REG_NUM);

    typedef enum logic [3:0] {
        S_IDLE, S_ID, S_ID_ACK, S_SUB, S_SUB_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_NA, S_IGNORE
    } state_t;

    state_t      r_state;
    logic [2:0]  r_c_sync;
    logic [2:0]  r_d_sync;
    logic [3:0]  r_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_ptr;
    logic        r_rw;
    logic [7:0]  r_regs [0:255];

    logic        w_rise, w_fall, w_start, w_stop, w_bit;
    logic [7:0]  w_byte, w_rd_byte, w_ptr_adv;
    logic        w_ptr_ok;

    // Synchronisers are deliberately not reset so a reset never fabricates a line edge.
    always_ff @(posedge clk) begin
        r_c_sync <= {r_c_sync[1:0], sio_c_i};
        r_d_sync <= {r_d_sync[1:0], sio_d_i};
    end

    assign w_rise    = r_c_sync[1] & ~r_c_sync[2];
    assign w_fall    = ~r_c_sync[1] & r_c_sync[2];
    assign w_start   = r_c_sync[1] & r_c_sync[2] & ~r_d_sync[1] & r_d_sync[2];
    assign w_stop    = r_c_sync[1] & r_c_sync[2] & r_d_sync[1] & ~r_d_sync[2];
    assign w_bit     = r_d_sync[1];
    assign w_byte    = {r_shift[6:0], w_bit};
    assign w_ptr_ok  = {1'b0, r_ptr} < LP_REG_NUM;
    assign w_rd_byte = w_ptr_ok ? r_regs[r_ptr] : '0;
`ifdef SMC_SLV_AUTO_INC_EN
    assign w_ptr_adv = r_ptr + 8'd1;
`else
    assign w_ptr_adv = r_ptr;
`endif

    always_comb begin
        dbg_data_o = '0;
        if ({1'b0, dbg_addr_i} < LP_REG_NUM) dbg_data_o = r_regs[dbg_addr_i];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_shift       <= '0;
            r_ptr         <= '0;
            r_rw          <= 1'b0;
            sio_d_oe_o    <= 1'b0;
            wr_evt_vld_o  <= 1'b0;
            wr_evt_addr_o <= '0;
            wr_evt_data_o <= '0;
            rd_evt_vld_o  <= 1'b0;
            busy_o        <= 1'b0;
            for (int unsigned i = 0; i < 256; i++) r_regs[i] <= REG_RST_VAL;
        end else begin
            wr_evt_vld_o <= 1'b0;
            rd_evt_vld_o <= 1'b0;
            if (w_stop) begin
                r_state    <= S_IDLE;
                r_cnt      <= '0;
                sio_d_oe_o <= 1'b0;
                busy_o     <= 1'b0;
            end else if (w_start) begin
                r_state    <= S_ID;
                r_cnt      <= '0;
                sio_d_oe_o <= 1'b0;
                busy_o     <= 1'b1;
            end else begin
                case (r_state)
                    S_ID, S_SUB, S_WDATA: begin
                        if (w_rise) begin
                            r_shift <= w_byte;
                            r_cnt   <= r_cnt + 4'd1;
                            if (r_cnt == 4'd7) begin
                                r_cnt <= '0;
                                if (r_state == S_ID) begin
                                    r_rw    <= w_byte[0];
                                    r_state <= (w_byte[7:1] == SLV_ID) ? S_ID_ACK : S_IGNORE;
                                end else if (r_state == S_SUB) begin
                                    r_ptr   <= w_byte;
                                    r_state <= S_SUB_ACK;
                                end else begin
                                    if (w_ptr_ok) begin
                                        r_regs[r_ptr] <= w_byte;
                                        wr_evt_vld_o  <= 1'b1;
                                        wr_evt_addr_o <= r_ptr;
                                        wr_evt_data_o <= w_byte;
                                    end
                                    r_ptr   <= w_ptr_adv;
                                    r_state <= S_WDATA_ACK;
                                end
                            end
                        end
                    end
                    // ACK is held from the first SIO_C fall to the second; the read
                    // path loads its first byte on that second fall.
                    S_ID_ACK, S_SUB_ACK, S_WDATA_ACK: begin
                        if (w_fall) begin
                            if (r_cnt == 4'd0) begin
                                sio_d_oe_o <= 1'b1;
                                r_cnt      <= 4'd1;
                            end else begin
                                r_cnt      <= '0;
                                sio_d_oe_o <= 1'b0;
                                if (r_state == S_ID_ACK && r_rw) begin
                                    r_shift      <= {w_rd_byte[6:0], 1'b0};
                                    sio_d_oe_o   <= ~w_rd_byte[7];
                                    rd_evt_vld_o <= 1'b1;
                                    r_ptr        <= w_ptr_adv;
                                    r_state      <= S_RDATA;
                                end else if (r_state == S_ID_ACK) begin
                                    r_state <= S_SUB;
                                end else begin
                                    r_state <= S_WDATA;
                                end
                            end
                        end
                    end
                    S_RDATA: begin
                        if (w_rise) r_cnt <= r_cnt + 4'd1;
                        if (w_fall && r_cnt != 4'd0) begin
                            if (r_cnt == 4'd8) begin
                                sio_d_oe_o <= 1'b0;
                                r_cnt      <= '0;
                                r_state    <= S_RDATA_NA;
                            end else begin
                                sio_d_oe_o <= ~r_shift[7];
                                r_shift    <= {r_shift[6:0], 1'b0};
                            end
                        end
                    end
                    S_RDATA_NA: begin
                        if (w_rise) begin
                            if (w_bit) r_state <= S_IGNORE;
                            else       r_cnt   <= 4'd1;
                        end
                        if (w_fall && r_cnt == 4'd1) begin
                            r_cnt        <= '0;
                            r_shift      <= {w_rd_byte[6:0], 1'b0};
                            sio_d_oe_o   <= ~w_rd_byte[7];
                            rd_evt_vld_o <= 1'b1;
                            r_ptr        <= w_ptr_adv;
                            r_state      <= S_RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
